alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 113 +++++++++++
 tb/tb_alu_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequences an external 16-bit ALU into 16-bit single-pass or 32-bit two-pass operations
// Ports: clk, rst_n (async, active-low); req_* request handshake with op/wide/cin/a/b;
//        alu_* drive and sample the external ALU; rsp_* response handshake with data and flags.
// Optional: define ALU_SEQ_OPCNT_EN to add op_count[15:0], a wrapping count of response handshakes.
module alu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic        req_wide,
  input  logic        req_cin,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [15:0] alu_in_1,
  output logic [15:0] alu_in_2,
  output logic        alu_carry_in,
  output logic [2:0]  alu_select,
  output logic        alu_enable,
  input  logic [15:0] alu_data,
  input  logic        alu_carry_out,
  input  logic        alu_zero_flag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_carry,
  output logic        rsp_zero
`ifdef ALU_SEQ_OPCNT_EN
  ,
  output logic [15:0] op_count
`endif
);
  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;
  state_t state;
  logic [2:0] op;
  logic wide;
  logic [15:0] a_hi, b_hi;
  // The low pass result lands in rsp_data[15:0] and its flags in rsp_carry/rsp_zero;
  // the high pass then overwrites the upper half and folds in its own flags.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      op <= '0;
      wide <= 1'b0;
      a_hi <= '0;
      b_hi <= '0;
      req_ready <= 1'b0;
      alu_enable <= 1'b0;
      alu_in_1 <= '0;
      alu_in_2 <= '0;
      alu_select <= '0;
      alu_carry_in <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_carry <= 1'b0;
      rsp_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= !(req_valid && req_ready);
          if (req_valid && req_ready) begin
            state <= LO;
            op <= req_op;
            wide <= req_wide;
            a_hi <= req_a[31:16];
            b_hi <= req_b[31:16];
            alu_enable <= 1'b1;
            alu_in_1 <= req_a[15:0];
            alu_in_2 <= req_b[15:0];
            alu_select <= req_op;
            alu_carry_in <= req_cin;
          end
        end
        LO: begin
          rsp_data <= {16'h0, alu_data};
          rsp_carry <= alu_carry_out;
          rsp_zero <= alu_zero_flag;
          alu_enable <= wide;
          alu_in_1 <= wide ? a_hi : '0;
          alu_in_2 <= wide ? b_hi : '0;
          alu_select <= wide ? op : '0;
          // carry chains only for add (0) and sub (1)
          alu_carry_in <= wide && op[2:1] == 2'b00 && alu_carry_out;
          rsp_valid <= !wide;
          state <= wide ? HI : RESP;
        end
        HI: begin
          rsp_data[31:16] <= alu_data;
          rsp_carry <= alu_carry_out;
          rsp_zero <= rsp_zero && alu_zero_flag;
          alu_enable <= 1'b0;
          alu_in_1 <= '0;
          alu_in_2 <= '0;
          alu_select <= '0;
          alu_carry_in <= 1'b0;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef ALU_SEQ_OPCNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) op_count <= '0;
    else if (rsp_valid && rsp_ready) op_count <= op_count + 16'd1;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed, table-driven check of alu_seq against a behavioural 16-bit ALU
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic        req_wide = 1'b0;
  logic        req_cin = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [15:0] alu_in_1, alu_in_2;
  logic        alu_carry_in;
  logic [2:0]  alu_select;
  logic        alu_enable;
  logic [15:0] alu_data;
  logic        alu_carry_out, alu_zero_flag;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_carry, rsp_zero;
`ifdef ALU_SEQ_OPCNT_EN
  logic [15:0] op_count;
  int exp_cnt = 0;
`endif

  alu_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_wide(req_wide),
    .req_cin(req_cin), .req_a(req_a), .req_b(req_b),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_carry_in(alu_carry_in),
    .alu_select(alu_select), .alu_enable(alu_enable), .alu_data(alu_data),
    .alu_carry_out(alu_carry_out), .alu_zero_flag(alu_zero_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
`ifdef ALU_SEQ_OPCNT_EN
    , .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU: add, sub (a + ~b + cin), and, or, xor, not a, else pass a.
  // Logic ops pass carry_in through to carry_out.
  logic [16:0] s;
  always_comb begin
    s = '0;
    case (alu_select)
      3'd0: s = {1'b0, alu_in_1} + {1'b0, alu_in_2} + {16'h0, alu_carry_in};
      3'd1: s = {1'b0, alu_in_1} + {1'b0, ~alu_in_2} + {16'h0, alu_carry_in};
      3'd2: s = {alu_carry_in, alu_in_1 & alu_in_2};
      3'd3: s = {alu_carry_in, alu_in_1 | alu_in_2};
      3'd4: s = {alu_carry_in, alu_in_1 ^ alu_in_2};
      3'd5: s = {alu_carry_in, ~alu_in_1};
      default: s = {alu_carry_in, alu_in_1};
    endcase
    alu_data = alu_enable ? s[15:0] : 16'h0;
    alu_carry_out = s[16];
    alu_zero_flag = s[15:0] == 16'h0;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        wide;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        c;
    logic        z;
    logic        hc;
  } vec_t;

  vec_t v[11];

  int          lat, en_cnt;
  logic [15:0] lo_in1, lo_in2;
  logic [2:0]  lo_sel;
  logic        lo_cin, hi_cin, en_at_rsp;
  logic [31:0] got_d;
  logic        got_c, got_z;

  // Issues one request and follows it until rsp_valid; lat counts cycles from the
  // accept cycle to the first cycle with rsp_valid high.
  task automatic do_op(input vec_t t, input logic rdy);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = t.op;
    req_wide = t.wide;
    req_cin = t.cin;
    req_a = t.a;
    req_b = t.b;
    rsp_ready = rdy;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 20), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_a = $urandom;
    req_b = $urandom;
    req_op = 3'($urandom);
    req_cin = ~t.cin;
    lat = 1;
    en_cnt = 0;
    hi_cin = 1'b0;
    while (!rsp_valid && lat < 10) begin
      if (alu_enable) begin
        if (en_cnt == 0) begin
          lo_in1 = alu_in_1;
          lo_in2 = alu_in_2;
          lo_sel = alu_select;
          lo_cin = alu_carry_in;
        end else hi_cin = alu_carry_in;
        en_cnt++;
      end
      @(negedge clk);
      lat++;
    end
    got_d = rsp_data;
    got_c = rsp_carry;
    got_z = rsp_zero;
    en_at_rsp = alu_enable;
`ifdef ALU_SEQ_OPCNT_EN
    if (rdy) exp_cnt++;
`endif
  endtask

  task automatic check_vec(input vec_t t, input int i);
    chk($sformatf("latency[%0d]", i), 32'(lat), t.wide ? 32'd3 : 32'd2);
    chk($sformatf("data[%0d]", i), got_d, t.d);
    chk($sformatf("carry[%0d]", i), 32'(got_c), 32'(t.c));
    chk($sformatf("zero[%0d]", i), 32'(got_z), 32'(t.z));
    chk($sformatf("passes[%0d]", i), 32'(en_cnt), t.wide ? 32'd2 : 32'd1);
    chk($sformatf("lo_in1[%0d]", i), 32'(lo_in1), 32'(t.a[15:0]));
    chk($sformatf("lo_in2[%0d]", i), 32'(lo_in2), 32'(t.b[15:0]));
    chk($sformatf("lo_sel[%0d]", i), 32'(lo_sel), 32'(t.op));
    chk($sformatf("lo_cin[%0d]", i), 32'(lo_cin), 32'(t.cin));
    if (t.wide) chk($sformatf("hi_cin[%0d]", i), 32'(hi_cin), 32'(t.hc));
    chk($sformatf("en_in_resp[%0d]", i), 32'(en_at_rsp), 32'd0);
  endtask

  initial begin
    //     op    wide  cin   a              b              data           c     z     hi cin
    v[0]  = '{3'd0, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
    v[1]  = '{3'd0, 1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b0, 1'b1};
    v[2]  = '{3'd5, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    v[3]  = '{3'd0, 1'b0, 1'b0, 32'hABCD_FFFF, 32'h1234_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    v[4]  = '{3'd0, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 1'b0, 1'b0, 1'b0};
    v[5]  = '{3'd1, 1'b1, 1'b1, 32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0};
    v[6]  = '{3'd2, 1'b1, 1'b1, 32'hF0F0_FFFF, 32'hFF00_000F, 32'hF000_000F, 1'b0, 1'b0, 1'b0};
    v[7]  = '{3'd4, 1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    v[8]  = '{3'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    v[9]  = '{3'd0, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    v[10] = '{3'd5, 1'b0, 1'b0, 32'hFFFF_FF00, 32'h0000_0000, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_enable", 32'(alu_enable), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_alu_ins", {alu_in_1, alu_in_2}, 32'd0);
    chk("rst_alu_ctl", {28'd0, alu_select, alu_carry_in}, 32'd0);
    chk("rst_flags", {30'd0, rsp_carry, rsp_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready_after_rst", 32'(req_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      do_op(v[i], 1'b1);
      check_vec(v[i], i);
    end

    // Backpressure: response must hold while rsp_ready is low; new requests ignored
    begin
      vec_t t;
      t = '{3'd0, 1'b0, 1'b0, 32'h0000_0007, 32'h0000_0009, 32'h0000_0010, 1'b0, 1'b0, 1'b0};
      do_op(t, 1'b0);
      chk("bp_latency", 32'(lat), 32'd2);
      for (int k = 0; k < 5; k++) begin
        req_valid = k[0];
        req_a = 32'h1111_1111 * k;
        @(negedge clk);
        chk($sformatf("bp_valid[%0d]", k), 32'(rsp_valid), 32'd1);
        chk($sformatf("bp_data[%0d]", k), rsp_data, t.d);
        chk($sformatf("bp_flags[%0d]", k), {30'd0, rsp_carry, rsp_zero}, 32'd0);
        chk($sformatf("bp_req_ready[%0d]", k), 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", 32'(rsp_valid), 32'd0);
      chk("bp_release_ready", 32'(req_ready), 32'd1);
`ifdef ALU_SEQ_OPCNT_EN
      exp_cnt++;
`endif
    end

    // Abort in the high pass
    begin
      int seen;
      @(negedge clk);
      req_valid = 1'b1;
      req_op = 3'd0;
      req_wide = 1'b1;
      req_cin = 1'b0;
      req_a = 32'h0000_FFFF;
      req_b = 32'h0000_0001;
      seen = 0;
      while (!req_ready && seen < 20) begin
        @(negedge clk);
        seen++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("abort_in_hi_enable", 32'(alu_enable), 32'd1);
      chk("abort_in_hi_cin", 32'(alu_carry_in), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_enable_drop", 32'(alu_enable), 32'd0);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (rsp_valid) seen++;
      end
      chk("abort_no_response", 32'(seen), 32'd0);
      chk("abort_ready_back", 32'(req_ready), 32'd1);
`ifdef ALU_SEQ_OPCNT_EN
      exp_cnt = 0;
`endif
    end

    do_op(v[1], 1'b1);
    check_vec(v[1], 99);
    @(negedge clk);
`ifdef ALU_SEQ_OPCNT_EN
    chk("op_count", 32'(op_count), 32'(exp_cnt[15:0]));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
